// File: rtl/mask_gen_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mask_gen_pipe
// Pipelined mask generator replacing the fixed left/right/dmask PROMs and
// adding a combined field mask. Two register stages with valid/ready flow
// control on both sides.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   in_valid / in_ready      request handshake
//   in_mode                  0=left, 1=right, 2=field, 3=dmask
//   in_hi, in_lo             bit addresses (in_hi is the length in dmask mode)
//   in_invert                complement the final mask
//   out_valid / out_ready    result handshake
//   out_mask                 WIDTH-bit mask
//   out_wrap                 field mode with lo > hi
//   out_ones                 population count of out_mask (0..WIDTH)
// ---------------------------------------------------------------------------
module mask_gen_pipe #(
    parameter  int WIDTH     = 32,
    parameter  int DMASK_MAX = 7,
    localparam int AW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [AW-1:0]    in_hi,
    input  logic [AW-1:0]    in_lo,
    input  logic             in_invert,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mask,
    output logic             out_wrap,
    output logic [AW:0]      out_ones
);

    localparam logic [1:0]       MODE_LEFT  = 2'd0;
    localparam logic [1:0]       MODE_RIGHT = 2'd1;
    localparam logic [1:0]       MODE_FIELD = 2'd2;
    localparam logic [1:0]       MODE_DMASK = 2'd3;
    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [AW-1:0]    MAX_ADDR   = AW'(WIDTH - 1);
    localparam logic [AW-1:0]    DMASK_LIM  = AW'(DMASK_MAX);

    // Population count of a mask vector.
    function automatic logic [AW:0] popcount(input logic [WIDTH-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

    // Flow control
    logic adv1_s, adv2_s;

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_l_q, s1_l_d;
    logic [WIDTH-1:0] s1_r_q, s1_r_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s1_wrap_q, s1_wrap_d;
    logic             s1_inv_q, s1_inv_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_mask_q, out_mask_d;
    logic             out_wrap_q, out_wrap_d;
    logic [AW:0]      out_ones_q, out_ones_d;

    // Front-end decode and stage-2 combine
    logic [WIDTH-1:0] lmask_s, rmask_s, lslot_s, comb_s, final_s;
    logic             wrap_s;

    // Handshake: S2 advances when empty or drained; S1 when empty or S2 advances.
    always_comb begin
        adv2_s   = !out_valid_q || out_ready;
        adv1_s   = !s1_valid_q || adv2_s;
        in_ready = adv1_s;
    end

    // Request decode: L(hi), R(lo), wrap flag. In dmask mode the left slot
    // carries the dmask (bits 0..n-1 = L(n-1)) so stage 2 needs no extra path.
    always_comb begin
        lmask_s = ALL_ONES >> (MAX_ADDR - in_hi);
        rmask_s = ALL_ONES << in_lo;
        if (in_mode == MODE_DMASK) begin
            if ((in_hi != '0) && (in_hi <= DMASK_LIM)) begin
                lslot_s = ALL_ONES >> (MAX_ADDR - (in_hi - AW'(1)));
            end else begin
                lslot_s = '0;
            end
        end else begin
            lslot_s = lmask_s;
        end
        if ((in_mode == MODE_FIELD) && (in_lo > in_hi)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Stage 1 next state: load on accept, clear valid when advancing empty.
    always_comb begin
        if (adv1_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (adv1_s && in_valid) begin
            s1_l_d    = lslot_s;
            s1_r_d    = rmask_s;
            s1_mode_d = in_mode;
            s1_wrap_d = wrap_s;
            s1_inv_d  = in_invert;
        end else begin
            s1_l_d    = s1_l_q;
            s1_r_d    = s1_r_q;
            s1_mode_d = s1_mode_q;
            s1_wrap_d = s1_wrap_q;
            s1_inv_d  = s1_inv_q;
        end
    end

    // Stage 2 combine: select by mode, then optional invert.
    always_comb begin
        case (s1_mode_q)
            MODE_LEFT:  comb_s = s1_l_q;
            MODE_RIGHT: comb_s = s1_r_q;
            MODE_FIELD: comb_s = s1_wrap_q ? (s1_l_q | s1_r_q) : (s1_l_q & s1_r_q);
            MODE_DMASK: comb_s = s1_l_q;
            default:    comb_s = s1_l_q;
        endcase
        if (s1_inv_q) begin
            final_s = ~comb_s;
        end else begin
            final_s = comb_s;
        end
    end

    // Stage 2 next state: data only changes when a new result moves in, so
    // the outputs hold while the consumer stalls.
    always_comb begin
        if (adv2_s) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (adv2_s && s1_valid_q) begin
            out_mask_d = final_s;
            out_wrap_d = s1_wrap_q;
            out_ones_d = popcount(final_s);
        end else begin
            out_mask_d = out_mask_q;
            out_wrap_d = out_wrap_q;
            out_ones_d = out_ones_q;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_l_q     <= '0;
            s1_r_q     <= '0;
            s1_mode_q  <= 2'd0;
            s1_wrap_q  <= 1'b0;
            s1_inv_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_l_q     <= s1_l_d;
            s1_r_q     <= s1_r_d;
            s1_mode_q  <= s1_mode_d;
            s1_wrap_q  <= s1_wrap_d;
            s1_inv_q   <= s1_inv_d;
        end
    end

    // Stage 2 (output) registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_wrap_q  <= 1'b0;
            out_ones_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_wrap_q  <= out_wrap_d;
            out_ones_q  <= out_ones_d;
        end
    end

    // Output drive
    always_comb begin
        out_valid = out_valid_q;
        out_mask  = out_mask_q;
        out_wrap  = out_wrap_q;
        out_ones  = out_ones_q;
    end

endmodule

// File: tb/tb_mask_gen_pipe.sv
`timescale 1ns/1ps
// Bench for mask_gen_pipe: a 32-bit instance (DMASK_MAX=7) for the main
// vectors, streaming and reset cases, and a 64-bit instance (DMASK_MAX=15).
module tb_mask_gen_pipe;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        a_in_valid, a_in_ready, a_in_invert, a_out_valid, a_out_ready, a_out_wrap;
    logic [1:0]  a_in_mode;
    logic [4:0]  a_in_hi, a_in_lo;
    logic [31:0] a_out_mask;
    logic [5:0]  a_out_ones;

    // 64-bit instance signals
    logic        b_in_valid, b_in_ready, b_in_invert, b_out_valid, b_out_ready, b_out_wrap;
    logic [1:0]  b_in_mode;
    logic [5:0]  b_in_hi, b_in_lo;
    logic [63:0] b_out_mask;
    logic [6:0]  b_out_ones;

    mask_gen_pipe #(.WIDTH(32), .DMASK_MAX(7)) u32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
        .in_hi(a_in_hi), .in_lo(a_in_lo), .in_invert(a_in_invert),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mask(a_out_mask),
        .out_wrap(a_out_wrap), .out_ones(a_out_ones)
    );

    mask_gen_pipe #(.WIDTH(64), .DMASK_MAX(15)) u64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_hi(b_in_hi), .in_lo(b_in_lo), .in_invert(b_in_invert),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mask(b_out_mask),
        .out_wrap(b_out_wrap), .out_ones(b_out_ones)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: build the mask bit by bit straight from the range rules.
    task automatic model(input int w, input int dmax, input int mode, input int hi,
                         input int lo, input bit inv, output logic [63:0] mask,
                         output int ones, output bit wrap);
        bit b;
        mask = '0;
        ones = 0;
        wrap = (mode == 2) && (lo > hi);
        for (int i = 0; i < w; i++) begin
            case (mode)
                0:       b = (i <= hi);
                1:       b = (i >= lo);
                2:       b = (lo <= hi) ? ((i >= lo) && (i <= hi)) : ((i <= hi) || (i >= lo));
                default: b = (hi <= dmax) && (i < hi);
            endcase
            if (inv) b = !b;
            mask[i] = b;
            ones += int'(b);
        end
    endtask

    typedef struct {
        int          mode;
        int          hi;
        int          lo;
        bit          inv;
        logic [31:0] mask;
        bit          wrap;
        int          ones;
    } vec_t;

    typedef struct {
        logic [31:0] mask;
        bit          wrap;
        int          ones;
    } res_t;

    localparam int NV = 17;
    vec_t vt[NV];
    res_t q[$];

    // One request through the 64-bit instance, result checked two edges later.
    task automatic run64(input string name, input int mode, input int hi, input int lo,
                         input bit inv, input logic [63:0] exp_mask, input int exp_ones);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_mode = 2'(mode); b_in_hi = 6'(hi);
        b_in_lo = 6'(lo); b_in_invert = inv;
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(b_out_valid), 64'd1);
        check({name, "_mask"}, b_out_mask, exp_mask);
        check({name, "_ones"}, 64'(b_out_ones), 64'(exp_ones));
    endtask

    initial begin
        logic [63:0] m;
        int          o;
        bit          w;
        int          sent, got, cyc, cnt;
        bit          stall;
        logic [31:0] hm;
        logic        hw;
        logic [5:0]  ho;

        a_in_valid = 1'b0; a_in_mode = 2'd0; a_in_hi = 5'd0; a_in_lo = 5'd0;
        a_in_invert = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 2'd0; b_in_hi = 6'd0; b_in_lo = 6'd0;
        b_in_invert = 1'b0; b_out_ready = 1'b1;

        vt[0]  = '{0, 4, 0, 1'b0, 32'h0000001F, 1'b0, 5};
        vt[1]  = '{1, 30, 4, 1'b0, 32'hFFFFFFF0, 1'b0, 28};
        vt[2]  = '{2, 15, 8, 1'b0, 32'h0000FF00, 1'b0, 8};
        vt[3]  = '{2, 3, 28, 1'b0, 32'hF000000F, 1'b1, 8};
        vt[4]  = '{2, 31, 31, 1'b0, 32'h80000000, 1'b0, 1};
        vt[5]  = '{3, 0, 9, 1'b0, 32'h00000000, 1'b0, 0};
        vt[6]  = '{3, 5, 9, 1'b0, 32'h0000001F, 1'b0, 5};
        vt[7]  = '{3, 7, 2, 1'b0, 32'h0000007F, 1'b0, 7};
        vt[8]  = '{3, 8, 0, 1'b0, 32'h00000000, 1'b0, 0};
        vt[9]  = '{3, 31, 31, 1'b0, 32'h00000000, 1'b0, 0};
        vt[10] = '{0, 31, 0, 1'b1, 32'h00000000, 1'b0, 0};
        vt[11] = '{1, 17, 0, 1'b1, 32'h00000000, 1'b0, 0};
        vt[12] = '{0, 0, 20, 1'b1, 32'hFFFFFFFE, 1'b0, 31};
        vt[13] = '{1, 0, 31, 1'b0, 32'h80000000, 1'b0, 1};
        vt[14] = '{2, 3, 28, 1'b1, 32'h0FFFFFF0, 1'b1, 24};
        vt[15] = '{0, 0, 25, 1'b0, 32'h00000001, 1'b0, 1};
        vt[16] = '{2, 0, 1, 1'b0, 32'hFFFFFFFF, 1'b1, 32};

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_ready", 64'(a_in_ready), 64'd1);
        check("rst_a_mask", 64'(a_out_mask), 64'd0);
        check("rst_a_wrap", 64'(a_out_wrap), 64'd0);
        check("rst_a_ones", 64'(a_out_ones), 64'd0);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_mask", b_out_mask, 64'd0);
        check("rst_b_ones", 64'(b_out_ones), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors back-to-back, no stall: result k appears two negedges later.
        for (int k = 0; k < NV + 3; k++) begin
            @(negedge clk);
            if (k >= 2 && k < NV + 2) begin
                check($sformatf("tbl%0d_valid", k - 2), 64'(a_out_valid), 64'd1);
                check($sformatf("tbl%0d_mask", k - 2), 64'(a_out_mask), 64'(vt[k-2].mask));
                check($sformatf("tbl%0d_wrap", k - 2), 64'(a_out_wrap), 64'(vt[k-2].wrap));
                check($sformatf("tbl%0d_ones", k - 2), 64'(a_out_ones), 64'(vt[k-2].ones));
            end else begin
                check($sformatf("tbl_idle%0d_valid", k), 64'(a_out_valid), 64'd0);
            end
            if (k < NV) begin
                check($sformatf("tbl%0d_ready", k), 64'(a_in_ready), 64'd1);
                a_in_valid = 1'b1; a_in_mode = 2'(vt[k].mode); a_in_hi = 5'(vt[k].hi);
                a_in_lo = 5'(vt[k].lo); a_in_invert = vt[k].inv;
            end else begin
                a_in_valid = 1'b0;
            end
        end

        // Random stream with random back-pressure against the reference model.
        sent = 0; got = 0; cyc = 0; stall = 1'b0;
        hm = '0; hw = 1'b0; ho = '0;
        while (got < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                check("hold_valid", 64'(a_out_valid), 64'd1);
                check("hold_mask", 64'(a_out_mask), 64'(hm));
                check("hold_wrap", 64'(a_out_wrap), 64'(hw));
                check("hold_ones", 64'(a_out_ones), 64'(ho));
            end
            a_out_ready = 1'($urandom_range(0, 1));
            if (sent < 8 && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1; a_in_mode = 2'($urandom_range(0, 3));
                a_in_hi = 5'($urandom_range(0, 31)); a_in_lo = 5'($urandom_range(0, 31));
                a_in_invert = 1'($urandom_range(0, 1));
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            stall = a_out_valid && !a_out_ready;
            if (stall) begin
                hm = a_out_mask; hw = a_out_wrap; ho = a_out_ones;
            end
            if (a_out_valid && a_out_ready) begin
                check("stream_pending", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    check($sformatf("stream%0d_mask", got), 64'(a_out_mask), 64'(q[0].mask));
                    check($sformatf("stream%0d_wrap", got), 64'(a_out_wrap), 64'(q[0].wrap));
                    check($sformatf("stream%0d_ones", got), 64'(a_out_ones), 64'(q[0].ones));
                    void'(q.pop_front());
                end
                got++;
            end
            if (a_in_valid && a_in_ready) begin
                model(32, 7, int'(a_in_mode), int'(a_in_hi), int'(a_in_lo), a_in_invert, m, o, w);
                q.push_back('{m[31:0], w, o});
                sent++;
            end
        end
        check("stream_count", 64'(got), 64'd8);
        check("stream_left", 64'(q.size()), 64'd0);
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        #1;
        check("stream_no_extra", 64'(a_out_valid), 64'd0);

        // Fill both stages under stall, then reset asynchronously mid-cycle.
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_mode = 2'd0; a_in_hi = 5'd7; a_in_lo = 5'd0; a_in_invert = 1'b0;
        @(negedge clk);
        a_in_mode = 2'd1; a_in_lo = 5'd3;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        check("full_ready", 64'(a_in_ready), 64'd0);
        check("full_valid", 64'(a_out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(a_out_valid), 64'd0);
        check("midrst_ready", 64'(a_in_ready), 64'd1);
        check("midrst_mask", 64'(a_out_mask), 64'd0);
        check("midrst_wrap", 64'(a_out_wrap), 64'd0);
        check("midrst_ones", 64'(a_out_ones), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_mode = 2'd2; a_in_hi = 5'd15; a_in_lo = 5'd8; a_in_invert = 1'b0;
        #1;
        check("post_rst_ready", 64'(a_in_ready), 64'd1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            if (a_out_valid) begin
                cnt++;
                check("post_rst_mask", 64'(a_out_mask), 64'h0000FF00);
            end
        end
        check("post_rst_count", 64'(cnt), 64'd1);

        // 64-bit instance with DMASK_MAX=15
        run64("w64_left63", 0, 63, 0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64);
        run64("w64_dm15", 3, 15, 0, 1'b0, 64'h0000000000007FFF, 15);
        run64("w64_dm16", 3, 16, 0, 1'b0, 64'h0000000000000000, 0);
        for (int k = 0; k < 6; k++) begin
            int md, h, l;
            bit iv;
            md = int'($urandom_range(0, 3));
            h = int'($urandom_range(0, 63));
            l = int'($urandom_range(0, 63));
            iv = 1'($urandom_range(0, 1));
            model(64, 15, md, h, l, iv, m, o, w);
            run64($sformatf("w64_rand%0d", k), md, h, l, iv, m, o);
            check($sformatf("w64_rand%0d_wrap", k), 64'(b_out_wrap), 64'(w));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
